// File: rtl/bfly_r2_pipe_pkg.sv
// Shared constants and elaboration-time twiddle math for the radix-2 butterfly.
// Twiddles are Q1.(TW_W-1) with +1.0 encoded as 2^(TW_W-1)-1; angles are Q28 fixed point.
package bfly_r2_pipe_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_TW_W      = 16;
  localparam int DEF_TW_ADDR_W = 4;
  localparam int DEF_TAG_W     = 8;
  localparam int BFLY_LAT      = 4;

  localparam int     ANG_FRAC = 28;
  localparam longint PI_Q28   = 64'sd843314857;

  // Taylor series in Q28, odd=1 gives sin(x), odd=0 gives cos(x); accurate for |x| <= pi.
  function automatic longint taylor_q28(input longint x, input logic odd);
    longint term;
    longint sum;
    term = odd ? x : (longint'(1) <<< ANG_FRAC);
    sum  = term;
    for (int i = 1; i <= 12; i++) begin
      term = (term * x) >>> ANG_FRAC;
      term = (term * x) >>> ANG_FRAC;
      term = -term / (odd ? longint'((2*i) * (2*i+1)) : longint'((2*i-1) * (2*i)));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Round-half-away-from-zero of a Q28 value scaled by 2^(tw_w-1)-1.
  function automatic longint tw_quant(input longint v, input int tw_w);
    longint m;
    longint p;
    longint half;
    m    = (longint'(1) <<< (tw_w - 1)) - 1;
    p    = v * m;
    half = longint'(1) <<< (ANG_FRAC - 1);
    if (p >= 0) return (p + half) >>> ANG_FRAC;
    else        return -((-p + half) >>> ANG_FRAC);
  endfunction

endpackage

// File: rtl/bfly_r2_pipe_twiddle_rom.sv
// Registered twiddle lookup: wr = cos(2*pi*k/N), wi = -sin(2*pi*k/N), wi negated for inverse.
// Table holds N/2 entries built at elaboration; k wraps naturally by its width.
module bfly_twiddle_rom
  import bfly_r2_pipe_pkg::*;
#(
  parameter int TW_ADDR_W = DEF_TW_ADDR_W,
  parameter int TW_W      = DEF_TW_W
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic [TW_ADDR_W-1:0]        k,
  input  logic                        inv,
  output logic signed [TW_W-1:0]      wr,
  output logic signed [TW_W-1:0]      wi
);

  localparam int DEPTH = 1 << TW_ADDR_W;

  logic signed [TW_W-1:0] cos_tab  [DEPTH];
  logic signed [TW_W-1:0] nsin_tab [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    localparam longint THETA = (PI_Q28 * longint'(g)) >>> TW_ADDR_W;
    localparam logic signed [TW_W-1:0] CV = TW_W'(tw_quant(taylor_q28(THETA, 1'b0), TW_W));
    localparam logic signed [TW_W-1:0] SV = TW_W'(-tw_quant(taylor_q28(THETA, 1'b1), TW_W));
    assign cos_tab[g]  = CV;
    assign nsin_tab[g] = SV;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      wr <= cos_tab[k];
      wi <= inv ? -nsin_tab[k] : nsin_tab[k];
    end
  end

endmodule

// File: rtl/bfly_r2_pipe.sv
// Fully pipelined radix-2 DIT butterfly, X = A + B*W, Y = A - B*W, 4-cycle latency, global stall.
// Define BFLY_SAT_EN to saturate the final reduction to DATA_W instead of wrapping.
module bfly_r2_pipe
  import bfly_r2_pipe_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TW_W      = DEF_TW_W,
  parameter int TW_ADDR_W = DEF_TW_ADDR_W,
  parameter int TAG_W     = DEF_TAG_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic signed [DATA_W-1:0]  i_ar,
  input  logic signed [DATA_W-1:0]  i_ai,
  input  logic signed [DATA_W-1:0]  i_br,
  input  logic signed [DATA_W-1:0]  i_bi,
  input  logic [TW_ADDR_W-1:0]      i_k,
  input  logic                      i_inv,
  input  logic                      i_scale,
  input  logic [TAG_W-1:0]          i_tag,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic signed [DATA_W-1:0]  o_xr,
  output logic signed [DATA_W-1:0]  o_xi,
  output logic signed [DATA_W-1:0]  o_yr,
  output logic signed [DATA_W-1:0]  o_yi,
  output logic [TAG_W-1:0]          o_tag
);

  localparam int PW = DATA_W + TW_W;
  localparam int EW = DATA_W + 2;

  function automatic logic signed [EW-1:0] rnd(input logic signed [PW:0] v);
    logic signed [PW:0] t;
    t = v + ((PW+1)'(1) <<< (TW_W - 2));
    return EW'(t >>> (TW_W - 1));
  endfunction

`ifdef BFLY_SAT_EN
  localparam logic signed [EW-1:0] SAT_HI = EW'((longint'(1) <<< (DATA_W - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_LO = -SAT_HI - EW'(1);

  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [EW-1:0] v);
    if (v > SAT_HI)      return DATA_W'(SAT_HI);
    else if (v < SAT_LO) return DATA_W'(SAT_LO);
    else                 return DATA_W'(v);
  endfunction
`else
  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [EW-1:0] v);
    return DATA_W'(v);
  endfunction
`endif

  function automatic logic signed [DATA_W-1:0] out_fmt(input logic signed [EW-1:0] v,
                                                       input logic s);
    logic signed [EW-1:0] t;
    t = v;
    if (s) begin
      t = v + EW'(1);
      t = t >>> 1;
    end
    return reduce(t);
  endfunction

  logic adv;
  assign adv     = ~o_valid | o_ready;
  assign i_ready = adv;

  // S0: operand capture and registered twiddle read
  logic                     vld_p0, scale_p0;
  logic signed [DATA_W-1:0] ar_p0, ai_p0, br_p0, bi_p0;
  logic signed [TW_W-1:0]   wr_p0, wi_p0;
  logic [TAG_W-1:0]         tag_p0;

  always_ff @(posedge clk) begin
    if (rst)      vld_p0 <= 1'b0;
    else if (adv) vld_p0 <= i_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      ar_p0    <= i_ar;
      ai_p0    <= i_ai;
      br_p0    <= i_br;
      bi_p0    <= i_bi;
      scale_p0 <= i_scale;
      tag_p0   <= i_tag;
    end
  end

  bfly_twiddle_rom #(.TW_ADDR_W(TW_ADDR_W), .TW_W(TW_W)) u_rom (
    .clk (clk),
    .en  (adv),
    .k   (i_k),
    .inv (i_inv),
    .wr  (wr_p0),
    .wi  (wi_p0)
  );

  // S1: four full-width products
  logic                     vld_p1, scale_p1;
  logic signed [DATA_W-1:0] ar_p1, ai_p1;
  logic signed [PW-1:0]     mrr_p1, mii_p1, mri_p1, mir_p1;
  logic [TAG_W-1:0]         tag_p1;

  always_ff @(posedge clk) begin
    if (rst)      vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      mrr_p1   <= PW'(br_p0) * PW'(wr_p0);
      mii_p1   <= PW'(bi_p0) * PW'(wi_p0);
      mri_p1   <= PW'(br_p0) * PW'(wi_p0);
      mir_p1   <= PW'(bi_p0) * PW'(wr_p0);
      ar_p1    <= ar_p0;
      ai_p1    <= ai_p0;
      scale_p1 <= scale_p0;
      tag_p1   <= tag_p0;
    end
  end

  // S2: complex product combine and round back to DATA_W+2
  logic                     vld_p2, scale_p2;
  logic signed [DATA_W-1:0] ar_p2, ai_p2;
  logic signed [EW-1:0]     pr_p2, pi_p2;
  logic [TAG_W-1:0]         tag_p2;

  always_ff @(posedge clk) begin
    if (rst)      vld_p2 <= 1'b0;
    else if (adv) vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      pr_p2    <= rnd((PW+1)'(mrr_p1) - (PW+1)'(mii_p1));
      pi_p2    <= rnd((PW+1)'(mri_p1) + (PW+1)'(mir_p1));
      ar_p2    <= ar_p1;
      ai_p2    <= ai_p1;
      scale_p2 <= scale_p1;
      tag_p2   <= tag_p1;
    end
  end

  // S3: add/subtract, optional halving, reduction to output width
  logic signed [EW-1:0] xr_s, xi_s, yr_s, yi_s;

  always_comb begin
    xr_s = EW'(ar_p2) + pr_p2;
    xi_s = EW'(ai_p2) + pi_p2;
    yr_s = EW'(ar_p2) - pr_p2;
    yi_s = EW'(ai_p2) - pi_p2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_xr    <= '0;
      o_xi    <= '0;
      o_yr    <= '0;
      o_yi    <= '0;
      o_tag   <= '0;
    end else if (adv) begin
      o_valid <= vld_p2;
      if (vld_p2) begin
        o_xr  <= out_fmt(xr_s, scale_p2);
        o_xi  <= out_fmt(xi_s, scale_p2);
        o_yr  <= out_fmt(yr_s, scale_p2);
        o_yi  <= out_fmt(yi_s, scale_p2);
        o_tag <= tag_p2;
      end
    end
  end

endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Directed bench for bfly_r2_pipe: vector table, stalled stream, back-to-back stream, mid-flight reset.
// Expected values for the overflow vectors follow BFLY_SAT_EN when it is defined.
module tb_bfly_r2_pipe;
  import bfly_r2_pipe_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid, i_ready;
  logic signed [15:0] i_ar, i_ai, i_br, i_bi;
  logic [3:0]         i_k;
  logic               i_inv, i_scale;
  logic [7:0]         i_tag;
  logic               o_valid, o_ready;
  logic signed [15:0] o_xr, o_xi, o_yr, o_yi;
  logic [7:0]         o_tag;

  bfly_r2_pipe #(.DATA_W(16), .TW_W(16), .TW_ADDR_W(4), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_ar(i_ar), .i_ai(i_ai), .i_br(i_br), .i_bi(i_bi),
    .i_k(i_k), .i_inv(i_inv), .i_scale(i_scale), .i_tag(i_tag),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_xr(o_xr), .o_xi(o_xi), .o_yr(o_yr), .o_yi(o_yi), .o_tag(o_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] ar, ai, br, bi;
    logic [3:0]         k;
    logic               inv, scale;
    logic signed [15:0] xr, xi, yr, yi;
  } vec_t;

  localparam int NV = 10;
  vec_t tv [NV];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int ar, input int ai, input int br, input int bi,
                         input int k, input int inv, input int scale,
                         input int xr, input int xi, input int yr, input int yi);
    tv[i].ar = 16'(ar);  tv[i].ai = 16'(ai);  tv[i].br = 16'(br);  tv[i].bi = 16'(bi);
    tv[i].k = 4'(k);     tv[i].inv = inv[0];  tv[i].scale = scale[0];
    tv[i].xr = 16'(xr);  tv[i].xi = 16'(xi);  tv[i].yr = 16'(yr);  tv[i].yi = 16'(yi);
  endtask

  // Stream item t: k=0, A=(100t, t), B=(10t, 0) -> X=(110t, t), Y=(90t, t)
  task automatic drive_stream(input int t);
    i_ar = 16'(t * 100); i_ai = 16'(t); i_br = 16'(t * 10); i_bi = 16'(0);
    i_k = 4'd0; i_inv = 1'b0; i_scale = 1'b0; i_tag = 8'(t); i_valid = 1'b1;
  endtask

  task automatic run_stream(input int n, input int st_lo, input int st_hi, input int tbase,
                            output int first_acc, output int first_out, output int last_out);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int t;
    logic prev_stall = 1'b0;
    logic signed [15:0] pxr = '0;
    logic [7:0] ptag = '0;
    first_acc = -1; first_out = -1; last_out = -1;
    while (got < n && cyc < 200) begin
      o_ready = !(cyc >= st_lo && cyc <= st_hi);
      if (sent < n) drive_stream(tbase + sent);
      else          i_valid = 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_xr", o_xr, pxr);
        chk("hold_tag", o_tag, ptag);
      end
      if (o_valid && !o_ready) chk("stall_i_ready", i_ready, 0);
      if (o_valid && o_ready) begin
        t = tbase + got;
        chk($sformatf("s%0d_tag", t), o_tag, 8'(t));
        chk($sformatf("s%0d_xr", t), o_xr, t * 110);
        chk($sformatf("s%0d_xi", t), o_xi, t);
        chk($sformatf("s%0d_yr", t), o_yr, t * 90);
        chk($sformatf("s%0d_yi", t), o_yi, t);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      if (i_valid && i_ready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      prev_stall = o_valid && !o_ready;
      pxr = o_xr;
      ptag = o_tag;
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    chk("stream_count", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, fa, fo, lo, extra;

    set_vec(0, 1000, 0, 2000, 0, 0, 0, 0, 3000, 0, -1000, 0);
    set_vec(1, 1000, 0, 2000, 0, 0, 0, 1, 1500, 0, -500, 0);
    set_vec(2, 0, 0, 1000, 0, 8, 0, 0, 0, -1000, 0, 1000);
    set_vec(3, 0, 0, 1000, 0, 8, 1, 0, 0, 1000, 0, -1000);
`ifdef BFLY_SAT_EN
    set_vec(4, 32767, 0, 32767, 0, 0, 0, 0, 32767, 0, 1, 0);
    set_vec(9, -32768, 0, 32767, 0, 0, 0, 0, -2, 0, -32768, 0);
`else
    set_vec(4, 32767, 0, 32767, 0, 0, 0, 0, -3, 0, 1, 0);
    set_vec(9, -32768, 0, 32767, 0, 0, 0, 0, -2, 0, 2, 0);
`endif
    set_vec(5, -500, 300, 100, -200, 0, 0, 0, -400, 100, -600, 500);
    set_vec(6, 10, 20, 0, 1000, 8, 0, 0, 1010, 20, -990, 20);
    set_vec(7, 0, 0, 1000, 0, 4, 0, 0, 707, -707, -707, 707);
    set_vec(8, -3, 5, 0, 0, 0, 0, 1, -1, 3, -1, 3);

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    i_ar = '0; i_ai = '0; i_br = '0; i_bi = '0; i_k = '0;
    i_inv = 1'b0; i_scale = 1'b0; i_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_xr", o_xr, 0);
    chk("rst_o_yi", o_yi, 0);
    chk("rst_o_tag", o_tag, 0);
    chk("rst_i_ready", i_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      i_ar = tv[i].ar; i_ai = tv[i].ai; i_br = tv[i].br; i_bi = tv[i].bi;
      i_k = tv[i].k; i_inv = tv[i].inv; i_scale = tv[i].scale; i_tag = 8'(i + 100);
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, BFLY_LAT);
      chk($sformatf("v%0d_xr", i), o_xr, tv[i].xr);
      chk($sformatf("v%0d_xi", i), o_xi, tv[i].xi);
      chk($sformatf("v%0d_yr", i), o_yr, tv[i].yr);
      chk($sformatf("v%0d_yi", i), o_yi, tv[i].yi);
      chk($sformatf("v%0d_tag", i), o_tag, i + 100);
    end
    @(posedge clk); #1;

    // Stalled stream: o_ready low for cycles 3..8
    run_stream(10, 3, 8, 0, fa, fo, lo);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid) extra++;
    end
    chk("stall_no_dup", extra, 0);
    @(posedge clk); #1;

    // Back-to-back stream, o_ready always high
    run_stream(8, -1, -1, 20, fa, fo, lo);
    chk("b2b_first_latency", fo - fa, BFLY_LAT);
    chk("b2b_throughput", lo - fo, 7);
    @(posedge clk); #1;

    // Fill the pipe against a stalled sink, then reset mid-flight
    o_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      drive_stream(50 + t);
      @(posedge clk); #1;
    end
    chk("pre_rst_o_valid", o_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_valid = 1'b0;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_xr", o_xr, 0);
    chk("midrst_o_yr", o_yr, 0);
    chk("midrst_o_tag", o_tag, 0);
    chk("midrst_i_ready", i_ready, 1);

    // Reset asserted together with a would-be accept
    drive_stream(70);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_valid) extra++;
    end
    chk("rst_no_stale", extra, 0);
    chk("post_rst_i_ready", i_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
